loop_ctrl_fsm: RTL and testbench

- Control stage directly upstream of the 3-bit up-counter in the CA1 datapath.
- Drives the counter's ld/inc/data inputs and consumes its carry flag.
- Sequences one operation per index value, from a programmable start index up to 7, with a req/ack handshake per operation.
- Reports busy, a one-cycle done pulse, and an iteration count.

---
 rtl/loop_ctrl_fsm_pkg.sv | 13 +
 rtl/up_counter_3bit.sv | 27 ++
 rtl/loop_ctrl_fsm.sv | 124 ++++++++++++
 tb/tb_loop_ctrl_fsm.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/loop_ctrl_fsm_pkg.sv
// Shared constants for the CA1 loop controller: state encoding and default index width.
package loop_ctrl_fsm_pkg;

    localparam int CNT_W_DEFAULT  = 3;
    localparam int ITER_W_DEFAULT = 4;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/up_counter_3bit.sv
// 3-bit index counter in the CA1 datapath: load beats increment, carry flags all-ones.
module up_counter_3bit (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ld,
    input  logic       i_inc,
    input  logic [2:0] i_data,
    output logic [2:0] o_cnt,
    output logic       o_carry
);

    logic [2:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 3'd0;
        end else if (i_ld) begin
            r_cnt <= i_data;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_carry = (r_cnt == 3'd7);

endmodule

// File: rtl/loop_ctrl_fsm.sv
// Loop controller driving the CA1 index counter: one req/ack operation per index from start_index up to all-ones.
//
// state | meaning
// IDLE  | waiting for start; all strobes low
// INIT  | load start_index into the counter
// ISSUE | op_req high until op_ack; carry decides DONE or STEP
// STEP  | one-cycle increment of the counter
// DONE  | one-cycle done pulse, then back to IDLE
module loop_ctrl_fsm
    import loop_ctrl_fsm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int ITER_W = ITER_W_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_start_index,
    input  logic              i_cnt_carry,
    input  logic              i_op_ack,
    output logic              o_cnt_ld,
    output logic              o_cnt_inc,
    output logic [CNT_W-1:0]  o_cnt_data,
    output logic              o_op_req,
    output logic              o_busy,
    output logic              o_done,
    output logic [ITER_W-1:0] o_iter_cnt
);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [CNT_W-1:0]  r_cnt_data;
    logic [ITER_W-1:0] r_iter_cnt;
    logic              w_launch;
    logic              w_op_accept;

    assign w_launch    = (r_state == S_IDLE) && i_start;
    // An abort on the same cycle as the ack wins, so that operation is not counted.
    assign w_op_accept = (r_state == S_ISSUE) && i_op_ack && !i_abort;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_INIT;
                end
            end
            S_INIT: begin
                w_next_state = i_abort ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (i_op_ack) begin
                    w_next_state = i_cnt_carry ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                w_next_state = i_abort ? S_IDLE : S_ISSUE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        o_cnt_ld  = 1'b0;
        o_cnt_inc = 1'b0;
        o_op_req  = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (r_state)
            S_INIT: begin
                o_cnt_ld = 1'b1;
                o_busy   = 1'b1;
            end
            S_ISSUE: begin
                o_op_req = 1'b1;
                o_busy   = 1'b1;
            end
            S_STEP: begin
                o_cnt_inc = 1'b1;
                o_busy    = 1'b1;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

    // Load value and iteration count are cleared by reset so a mid-loop reset leaves a clean view.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt_data <= '0;
            r_iter_cnt <= '0;
        end else if (w_launch) begin
            r_cnt_data <= i_start_index;
            r_iter_cnt <= '0;
        end else if (w_op_accept) begin
            r_iter_cnt <= r_iter_cnt + ITER_W'(1);
        end
    end

    assign o_cnt_data = r_cnt_data;
    assign o_iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_loop_ctrl_fsm.sv
// Directed bench for loop_ctrl_fsm wired to the 3-bit index counter.
module tb_loop_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [2:0] start_index;
    logic       op_ack;
    logic       cnt_ld;
    logic       cnt_inc;
    logic [2:0] cnt_data;
    logic       op_req;
    logic       busy;
    logic       done;
    logic [3:0] iter_cnt;
    logic [2:0] cnt_q;
    logic       cnt_carry;

    int checks   = 0;
    int failures = 0;

    int n_req, n_inc, n_done, entries, done_cyc, overlap, cnt_bad, abort_lat;
    bit fin;

    loop_ctrl_fsm #(.CNT_W(3), .ITER_W(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_abort       (abort),
        .i_start_index (start_index),
        .i_cnt_carry   (cnt_carry),
        .i_op_ack      (op_ack),
        .o_cnt_ld      (cnt_ld),
        .o_cnt_inc     (cnt_inc),
        .o_cnt_data    (cnt_data),
        .o_op_req      (op_req),
        .o_busy        (busy),
        .o_done        (done),
        .o_iter_cnt    (iter_cnt)
    );

    up_counter_3bit u_cnt (
        .i_clk   (clk),
        .i_rst   (~reset),
        .i_ld    (cnt_ld),
        .i_inc   (cnt_inc),
        .i_data  (cnt_data),
        .o_cnt   (cnt_q),
        .o_carry (cnt_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launches one loop and samples every cycle at the falling edge; d = extra ack delay per op.
    task automatic run_loop(input logic [2:0] idx, input int d, input int abort_at,
                            input bit spur, input bit abort_with_start);
        int cyc;
        int run;
        int abort_cyc;
        n_req = 0; n_inc = 0; n_done = 0; entries = 0; overlap = 0; cnt_bad = 0;
        done_cyc = -1; abort_lat = -1; abort_cyc = -1; run = 0; fin = 0;
        @(negedge clk);
        start_index = idx;
        start       = 1'b1;
        abort       = abort_with_start;
        op_ack      = (d == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            abort = 1'b0;
            if (cnt_ld && cnt_inc) overlap++;
            if (op_req && (cnt_ld || cnt_inc)) overlap++;
            if (cnt_inc) n_inc++;
            if (op_req) begin
                n_req++;
                run++;
                if (run == 1) begin
                    entries++;
                    if (int'(cnt_q) != int'(idx) + entries - 1) cnt_bad++;
                end
            end else begin
                run = 0;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                fin = 1;
            end
            if (abort_cyc >= 0 && !busy) begin
                abort_lat = cyc - abort_cyc;
                fin = 1;
            end
            if (d == 0) op_ack = 1'b1;
            else        op_ack = op_req && (run > d);
            if (spur && cnt_inc) op_ack = 1'b1;
            if (spur && cyc == 3) start = 1'b1;
            if (abort_at > 0 && abort_cyc < 0 && op_req && entries == abort_at) begin
                abort     = 1'b1;
                op_ack    = 1'b0;
                abort_cyc = cyc;
            end
        end
        check("loop_finished", int'(fin), 1);
        op_ack = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        start_index = 3'd0;
        op_ack      = 1'b0;

        #3;
        check("rst_busy",     int'(busy),     0);
        check("rst_op_req",   int'(op_req),   0);
        check("rst_done",     int'(done),     0);
        check("rst_strobes",  int'({cnt_ld, cnt_inc}), 0);
        check("rst_iter_cnt", int'(iter_cnt), 0);
        check("rst_cnt_data", int'(cnt_data), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Full loop from index 0 with ack tied high
        run_loop(3'd0, 0, 0, 1'b0, 1'b0);
        check("full_done_cyc", done_cyc, 17);
        check("full_req_cyc",  n_req,    8);
        check("full_ops",      entries,  8);
        check("full_inc",      n_inc,    7);
        check("full_iter",     int'(iter_cnt), 8);
        check("full_done_cnt", n_done,   1);
        check("full_cnt_seq",  cnt_bad,  0);
        check("full_overlap",  overlap,  0);
        check("full_cnt_end",  int'(cnt_q), 7);
        check("full_idle",     int'(busy), 0);

        // Single-op loop from index 7
        run_loop(3'd7, 0, 0, 1'b0, 1'b0);
        check("short_done_cyc", done_cyc, 3);
        check("short_req_cyc",  n_req,    1);
        check("short_inc",      n_inc,    0);
        check("short_iter",     int'(iter_cnt), 1);
        check("short_cnt_seq",  cnt_bad,  0);

        // Stalled handshake, ack three cycles late
        run_loop(3'd5, 3, 0, 1'b0, 1'b0);
        check("stall_done_cyc", done_cyc, 16);
        check("stall_req_cyc",  n_req,    12);
        check("stall_ops",      entries,  3);
        check("stall_iter",     int'(iter_cnt), 3);
        check("stall_cnt_end",  int'(cnt_q), 7);
        check("stall_cnt_seq",  cnt_bad,  0);
        check("stall_overlap",  overlap,  0);

        // Abort during the third ISSUE before its ack
        run_loop(3'd2, 0, 3, 1'b0, 1'b0);
        check("abort_latency", abort_lat, 1);
        check("abort_no_done", n_done,    0);
        check("abort_iter",    int'(iter_cnt), 2);
        check("abort_ops",     entries,   3);
        check("abort_inc",     n_inc,     2);
        check("abort_cnt_end", int'(cnt_q), 4);

        // Start pulsed while busy, ack pulsed during STEP
        run_loop(3'd4, 1, 0, 1'b1, 1'b0);
        check("spur_done_cyc", done_cyc, 13);
        check("spur_ops",      entries,  4);
        check("spur_iter",     int'(iter_cnt), 4);
        check("spur_inc",      n_inc,    3);
        check("spur_done_cnt", n_done,   1);
        check("spur_overlap",  overlap,  0);

        // Clean rerun, with abort coinciding with start in IDLE
        run_loop(3'd6, 0, 0, 1'b0, 1'b1);
        check("rerun_done_cyc", done_cyc, 5);
        check("rerun_iter",     int'(iter_cnt), 2);
        check("rerun_done_cnt", n_done,   1);
        check("rerun_cnt_seq",  cnt_bad,  0);

        // Asynchronous reset in the middle of an ISSUE
        @(negedge clk);
        start_index = 3'd0;
        start       = 1'b1;
        op_ack      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        op_ack = 1'b0;
        @(negedge clk);
        check("pre_rst_req",  int'(op_req),   1);
        check("pre_rst_iter", int'(iter_cnt), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_req",  int'(op_req),   0);
        check("async_rst_busy", int'(busy),     0);
        check("async_rst_iter", int'(iter_cnt), 0);
        check("async_rst_data", int'(cnt_data), 0);
        check("async_rst_strb", int'({cnt_ld, cnt_inc, done}), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
